data_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port `data_memory` (64-bit words, 128 words, combinational read, write on the rising clock edge) between the CPU load/store unit (port 0) and the program loader/debug port (port 1). Each port uses a valid/ready request handshake and receives exactly one registered response per accepted request. Fairness is round-robin. Misaligned and out-of-range accesses are rejected without touching memory. An optional lock keeps multi-beat sequences atomic.

---
 rtl/data_mem_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 16 +
 rtl/data_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared constants, types and the address legality rule for the data-memory arbiter.
package data_mem_arb_pkg;

  localparam int XLEN      = 64;
  localparam int MEM_WORDS = 128;

  typedef logic port_id_t;

  typedef enum logic {LK_FREE, LK_OWNED} lock_state_e;

  // Word aligned and inside the memory; callers with a non-default depth pass it in.
  function automatic logic addr_legal(input logic [XLEN-1:0] addr,
                                      input int unsigned      words = MEM_WORDS);
    return (addr[2:0] == 3'b000) && (addr < (XLEN'(words) << 3));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the port that did not win last time is granted.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  output logic [1:0] gnt
);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the LSU (port 0) and the
// loader/debug port (port 1). Define DATA_MEM_ARB_LOCK_EN to compile in the multi-beat lock.
module data_mem_arbiter #(
  parameter int XLEN      = 64,
  parameter int MEM_WORDS = 128,
  parameter int LOCK_MAX  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req_valid,
  output logic            p0_req_ready,
  input  logic [XLEN-1:0] p0_req_addr,
  input  logic            p0_req_we,
  input  logic [XLEN-1:0] p0_req_wdata,
`ifdef DATA_MEM_ARB_LOCK_EN
  input  logic            p0_req_lock,
  input  logic            p1_req_lock,
`endif
  output logic            p0_rsp_valid,
  output logic [XLEN-1:0] p0_rsp_data,
  output logic            p0_rsp_err,
  input  logic            p1_req_valid,
  output logic            p1_req_ready,
  input  logic [XLEN-1:0] p1_req_addr,
  input  logic            p1_req_we,
  input  logic [XLEN-1:0] p1_req_wdata,
  output logic            p1_rsp_valid,
  output logic [XLEN-1:0] p1_rsp_data,
  output logic            p1_rsp_err,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [XLEN-1:0] mem_read_data
);
  import data_mem_arb_pkg::*;

  if (LOCK_MAX < 1) begin : g_lock_max_check
    $error("LOCK_MAX must be at least 1");
  end

  port_id_t        last_grant;
  port_id_t        sel;
  logic [1:0]      req_vec;
  logic [1:0]      gnt;
  logic            hs;
  logic            legal;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic            sel_we;
  logic [1:0]      rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Gating with rst keeps every output low during reset and aborts any in-flight beat.
  assign hs        = (|gnt) && !rst;
  assign sel       = gnt[1];
  assign sel_addr  = sel ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = sel ? p1_req_wdata : p0_req_wdata;
  assign sel_we    = sel ? p1_req_we    : p0_req_we;
  assign legal     = addr_legal(sel_addr, MEM_WORDS);

  assign p0_req_ready = hs && !sel;
  assign p1_req_ready = hs && sel;

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    if (hs && legal) begin
      mem_address    = sel_addr;
      mem_write_data = sel_wdata;
      mem_write_en   = sel_we;
      mem_read_en    = !sel_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= {hs && sel, hs && !sel};
      if (hs) begin
        last_grant <= sel;
        rsp_data   <= (legal && !sel_we) ? mem_read_data : '0;
        rsp_err    <= !legal;
      end
    end
  end

  assign p0_rsp_valid = rsp_valid[0];
  assign p0_rsp_data  = rsp_valid[0] ? rsp_data : '0;
  assign p0_rsp_err   = rsp_valid[0] && rsp_err;
  assign p1_rsp_valid = rsp_valid[1];
  assign p1_rsp_data  = rsp_valid[1] ? rsp_data : '0;
  assign p1_rsp_err   = rsp_valid[1] && rsp_err;

`ifdef DATA_MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e      lk_state, lk_state_nxt;
  port_id_t         owner, owner_nxt;
  logic [CNT_W-1:0] beats, beats_nxt;
  logic             sel_lock;

  assign sel_lock = sel ? p1_req_lock : p0_req_lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_state <= LK_FREE;
      owner    <= 1'b0;
      beats    <= '0;
    end else begin
      lk_state <= lk_state_nxt;
      owner    <= owner_nxt;
      beats    <= beats_nxt;
    end
  end

  // The locking beat counts as the first owned beat; beat LOCK_MAX always releases.
  always_comb begin
    lk_state_nxt = lk_state;
    owner_nxt    = owner;
    beats_nxt    = beats;
    if (hs) begin
      if (sel_lock && (int'(beats) + 1 < LOCK_MAX)) begin
        lk_state_nxt = LK_OWNED;
        owner_nxt    = sel;
        beats_nxt    = beats + CNT_W'(1);
      end else begin
        lk_state_nxt = LK_FREE;
        owner_nxt    = 1'b0;
        beats_nxt    = '0;
      end
    end
  end

  // An owned lock hides the other port even while the owner is idle.
  always_comb begin
    req_vec = {p1_req_valid, p0_req_valid};
    if (lk_state == LK_OWNED) begin
      if (owner) req_vec[0] = 1'b0;
      else       req_vec[1] = 1'b0;
    end
  end
`else
  assign req_vec = {p1_req_valid, p0_req_valid};
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a transaction-level reference model.
module tb_data_mem_arbiter;
  localparam int XLEN      = 64;
  localparam int MEM_WORDS = 128;
  localparam int LOCK_MAX  = 16;
`ifdef DATA_MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            p0_req_valid = 1'b0, p0_req_we = 1'b0, p0_req_lock = 1'b0;
  logic            p1_req_valid = 1'b0, p1_req_we = 1'b0, p1_req_lock = 1'b0;
  logic [XLEN-1:0] p0_req_addr = '0, p0_req_wdata = '0;
  logic [XLEN-1:0] p1_req_addr = '0, p1_req_wdata = '0;
  logic            p0_req_ready, p1_req_ready;
  logic            p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [XLEN-1:0] p0_rsp_data, p1_rsp_data;
  logic [XLEN-1:0] mem_address, mem_write_data, mem_read_data;
  logic            mem_write_en, mem_read_en;

  int checks = 0;
  int errors = 0;
  int p1_rsp_seen = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.XLEN(XLEN), .MEM_WORDS(MEM_WORDS), .LOCK_MAX(LOCK_MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .p0_req_valid   (p0_req_valid),
    .p0_req_ready   (p0_req_ready),
    .p0_req_addr    (p0_req_addr),
    .p0_req_we      (p0_req_we),
    .p0_req_wdata   (p0_req_wdata),
`ifdef DATA_MEM_ARB_LOCK_EN
    .p0_req_lock    (p0_req_lock),
    .p1_req_lock    (p1_req_lock),
`endif
    .p0_rsp_valid   (p0_rsp_valid),
    .p0_rsp_data    (p0_rsp_data),
    .p0_rsp_err     (p0_rsp_err),
    .p1_req_valid   (p1_req_valid),
    .p1_req_ready   (p1_req_ready),
    .p1_req_addr    (p1_req_addr),
    .p1_req_we      (p1_req_we),
    .p1_req_wdata   (p1_req_wdata),
    .p1_rsp_valid   (p1_rsp_valid),
    .p1_rsp_data    (p1_rsp_data),
    .p1_rsp_err     (p1_rsp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data)
  );

  // Stand-in for data_memory: combinational read, write on the rising edge.
  logic [XLEN-1:0] mem [MEM_WORDS] = '{default: '0};
  assign mem_read_data = mem[mem_address[9:3]];
  always @(posedge clk) if (mem_write_en) mem[mem_address[9:3]] <= mem_write_data;

  always @(negedge clk) if (p1_rsp_valid && !p1_rsp_err) p1_rsp_seen <= p1_rsp_seen + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal_addr(input logic [XLEN-1:0] a);
    return (a % 64'd8 == 64'd0) && (a < 64'(8 * MEM_WORDS));
  endfunction

  // Reference model: who should win, what memory sees, and what each response must carry.
  logic [XLEN-1:0] ref_mem [MEM_WORDS] = '{default: '0};
  int              last_win = 1, owner = -1, beats = 0;
  int              exp_port = -1;
  logic [XLEN-1:0] exp_data = '0;
  logic            exp_err = 1'b0;

  initial begin : compare
    int              win;
    logic            c_we, c_lock, c_legal;
    logic [XLEN-1:0] c_addr, c_wdata;
    forever begin
      @(negedge clk);
      win = -1;
      c_we = 1'b0; c_lock = 1'b0; c_legal = 1'b0; c_addr = '0; c_wdata = '0;
      if (rst) begin
        checkb("rst_p0_ready", p0_req_ready, 1'b0);
        checkb("rst_p1_ready", p1_req_ready, 1'b0);
        checkb("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
        checkb("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
        check("rst_p0_rsp_data", p0_rsp_data, '0);
        check("rst_p1_rsp_data", p1_rsp_data, '0);
        checkb("rst_p0_rsp_err", p0_rsp_err, 1'b0);
        checkb("rst_p1_rsp_err", p1_rsp_err, 1'b0);
        check("rst_mem_address", mem_address, '0);
        check("rst_mem_write_data", mem_write_data, '0);
        checkb("rst_mem_write_en", mem_write_en, 1'b0);
        checkb("rst_mem_read_en", mem_read_en, 1'b0);
      end else begin
        checkb("p0_rsp_valid", p0_rsp_valid, exp_port == 0);
        checkb("p1_rsp_valid", p1_rsp_valid, exp_port == 1);
        if (exp_port == 0) begin
          check("p0_rsp_data", p0_rsp_data, exp_data);
          checkb("p0_rsp_err", p0_rsp_err, exp_err);
        end
        if (exp_port == 1) begin
          check("p1_rsp_data", p1_rsp_data, exp_data);
          checkb("p1_rsp_err", p1_rsp_err, exp_err);
        end
        if (p0_req_valid && owner != 1 && p1_req_valid && owner != 0) win = 1 - last_win;
        else if (p0_req_valid && owner != 1) win = 0;
        else if (p1_req_valid && owner != 0) win = 1;
        checkb("p0_req_ready", p0_req_ready, win == 0);
        checkb("p1_req_ready", p1_req_ready, win == 1);
        if (win == 0) begin
          c_addr = p0_req_addr; c_wdata = p0_req_wdata; c_we = p0_req_we; c_lock = p0_req_lock;
        end else if (win == 1) begin
          c_addr = p1_req_addr; c_wdata = p1_req_wdata; c_we = p1_req_we; c_lock = p1_req_lock;
        end
        c_legal = (win >= 0) && legal_addr(c_addr);
        checkb("mem_write_en", mem_write_en, c_legal && c_we);
        checkb("mem_read_en", mem_read_en, c_legal && !c_we);
        check("mem_address", mem_address, c_legal ? c_addr : '0);
        check("mem_write_data", mem_write_data, c_legal ? c_wdata : '0);
      end
      @(posedge clk or posedge rst);
      if (rst) begin
        last_win = 1; owner = -1; beats = 0; exp_port = -1;
      end else begin
        exp_port = win;
        if (win >= 0) begin
          exp_err  = !c_legal;
          exp_data = (c_legal && !c_we) ? ref_mem[c_addr[9:3]] : '0;
          if (c_legal && c_we) ref_mem[c_addr[9:3]] = c_wdata;
          last_win = win;
          if (LOCK_EN && c_lock) begin
            if (owner < 0) owner = win;
            beats++;
            if (beats == LOCK_MAX) begin owner = -1; beats = 0; end
          end else begin
            owner = -1; beats = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] d, input logic lk);
    p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d; p0_req_lock = lk;
  endtask

  task automatic set1(input logic v, input logic we, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] d, input logic lk);
    p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d; p1_req_lock = lk;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, '0, '0, 1'b0);
    set1(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [XLEN-1:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)  return 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd8;
    if (r == 7) return 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd8 + 64'($urandom_range(1, 7));
    if (r == 8) return 64'($urandom_range(8 * MEM_WORDS, 4095));
    return {$urandom, $urandom};
  endfunction

  initial begin : stim
    int base;
    // Reset held with a pending write from port 1.
    set1(1'b1, 1'b1, 64'd8, 64'd5, 1'b0);
    set0(1'b1, 1'b0, 64'd0, '0, 1'b0);
    repeat (3) begin
      step(); #2;
      checkb("hold_rst_p1_ready", p1_req_ready, 1'b0);
      checkb("hold_rst_mem_we", mem_write_en, 1'b0);
    end
    idle();
    rst = 1'b0;
    step();
    check("mem_word1_after_rst", mem[1], '0);

    base = p1_rsp_seen;
    for (int n = 0; n < MEM_WORDS; n++) begin
      step();
      set1(1'b1, 1'b1, 64'(n) * 64'd8, 64'(n), 1'b0);
      #2;
      checkb("fill_p1_ready", p1_req_ready, 1'b1);
    end
    step(); idle();
    step();
    check("fill_rsp_count", 64'(p1_rsp_seen - base), 64'(MEM_WORDS));

    for (int n = 0; n < MEM_WORDS; n++) begin
      step();
      set0(1'b1, 1'b0, 64'(n) * 64'd8, '0, 1'b0);
      #2;
      checkb("read_p0_ready", p0_req_ready, 1'b1);
      if (n > 0) check("read_p0_data", p0_rsp_data, 64'(n - 1));
    end
    step(); idle(); #2;
    check("read_p0_data_last", p0_rsp_data, 64'(MEM_WORDS - 1));

    // One port-1 beat first so port 0 wins the opening tie.
    step();
    set1(1'b1, 1'b1, 64'd40, 64'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      set0(1'b1, 1'b0, 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd8, '0, 1'b0);
      set1(1'b1, 1'b0, 64'($urandom_range(0, MEM_WORDS - 1)) * 64'd8, '0, 1'b0);
      #2;
      checkb("tie_p0_ready", p0_req_ready, i % 2 == 0);
      checkb("tie_p1_ready", p1_req_ready, i % 2 == 1);
      checkb("tie_p0_rsp_valid", p0_rsp_valid, i % 2 == 1);
    end

    step(); idle();
    set0(1'b1, 1'b0, 64'd12, '0, 1'b0);
    #2;
    checkb("misalign_read_en", mem_read_en, 1'b0);
    checkb("misalign_ready", p0_req_ready, 1'b1);
    step();
    set0(1'b1, 1'b1, 64'd1024, 64'hdead, 1'b0);
    #2;
    checkb("misalign_err", p0_rsp_err, 1'b1);
    check("misalign_data", p0_rsp_data, '0);
    checkb("range_write_en", mem_write_en, 1'b0);
    step(); idle(); #2;
    checkb("range_err", p0_rsp_err, 1'b1);
    step();
    check("range_mem0_kept", mem[0], '0);

    for (int i = 0; i < 1500; i++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) rst = 1'b1;
      set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
           LOCK_EN && ($urandom_range(0, 2) == 0));
      set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
           LOCK_EN && ($urandom_range(0, 2) == 0));
    end
    step(); idle(); rst = 1'b0;
    step();
    for (int w = 0; w < MEM_WORDS; w += 17) check("mem_vs_model", mem[w], ref_mem[w]);

`ifdef DATA_MEM_ARB_LOCK_EN
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, 1'b0, 64'(i) * 64'd8, '0, 1'b1);
      set1(1'b1, 1'b0, 64'd0, '0, 1'b0);
      #2;
      checkb("lock_hold_p0_ready", p0_req_ready, 1'b1);
      checkb("lock_hold_p1_ready", p1_req_ready, 1'b0);
      step();
    end
    set0(1'b1, 1'b0, 64'd24, '0, 1'b0);
    #2;
    checkb("lock_last_p1_ready", p1_req_ready, 1'b0);
    step(); #2;
    checkb("lock_after_p1_ready", p1_req_ready, 1'b1);

    step(); idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set0(1'b1, 1'b0, 64'(i % MEM_WORDS) * 64'd8, '0, 1'b1);
      set1(1'b1, 1'b0, 64'd16, '0, 1'b0);
      #2;
      checkb("lock_timeout_p1_ready", p1_req_ready, i == LOCK_MAX);
      if (i == LOCK_MAX) break;
      step();
    end

    step(); idle(); rst = 1'b1; step(); rst = 1'b0;
    set0(1'b1, 1'b0, 64'd0, '0, 1'b1);
    set1(1'b1, 1'b0, 64'd0, '0, 1'b0);
    step(); step(); #2;
    rst = 1'b1;
    step(); rst = 1'b0;
    set0(1'b1, 1'b0, 64'd0, '0, 1'b0);
    #2;
    checkb("rst_lock_p0_first", p0_req_ready, 1'b1);
    checkb("rst_lock_p1_blocked", p1_req_ready, 1'b0);
`endif

    step(); idle();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
